mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly after the execute stage: consumes the 149-bit `reg_ex_mem` pipeline register and produces the `reg_mem_wb` register for write-back. Issues loads and stores to data memory over a req/ready handshake, stalls execute while an access is outstanding, and formats load data with byte/halfword extraction and sign or zero extension. Non-memory records pass through in one cycle.

---
 rtl/mem_pkg.sv | 56 +++++
 rtl/mem_load_format.sv | 34 +++
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: opcodes, pipeline-register layouts and FSM states.
package mem_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned WE_W     = 4;
  localparam int unsigned IMM_W    = 32;
  localparam int unsigned EX_MEM_W = 149;
  localparam int unsigned MEM_WB_W = 83;

  localparam logic [OP_W-1:0] OP_LB  = 6'd10;
  localparam logic [OP_W-1:0] OP_LH  = 6'd11;
  localparam logic [OP_W-1:0] OP_LW  = 6'd12;
  localparam logic [OP_W-1:0] OP_LBU = 6'd13;
  localparam logic [OP_W-1:0] OP_LHU = 6'd14;
  localparam logic [OP_W-1:0] OP_SB  = 6'd15;
  localparam logic [OP_W-1:0] OP_SH  = 6'd16;
  localparam logic [OP_W-1:0] OP_SW  = 6'd17;

  // Field order MSB..LSB fixes the bit positions of reg_ex_mem (pc at [31:0] .. ctrl_we at [148]).
  typedef struct packed {
    logic             ctrl_we;
    logic [OP_W-1:0]  opcode;
    logic [IMM_W-1:0] imm;
    logic [WE_W-1:0]  we;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs1;
    logic [XLEN-1:0]  rv2;
    logic [XLEN-1:0]  alu_out;
    logic [XLEN-1:0]  pc;
  } ex_mem_t;

  // reg_mem_wb layout: pc at [31:0] .. err at [82].
  typedef struct packed {
    logic             err;
    logic             valid;
    logic             ctrl_we;
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs1;
    logic [XLEN-1:0]  wb_data;
    logic [XLEN-1:0]  pc;
  } mem_wb_t;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

endpackage

// File: rtl/mem_load_format.sv
// Load data formatting: byte/halfword lane select with sign or zero extension.
module mem_load_format
  import mem_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  input  logic [1:0]      i_addr,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_rdata[7:0];
    w_half   = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data_c = i_rdata;
    case (i_addr)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    case (i_opcode)
      OP_LB:   o_data_c = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data_c = {24'd0, w_byte};
      OP_LH:   o_data_c = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data_c = {16'd0, w_half};
      OP_LW:   o_data_c = i_rdata;
      default: o_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over req/ready, stalls execute, formats load data.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [EX_MEM_W-1:0] reg_ex_mem,
  output logic                ex_mem_stall,
  output logic [MEM_WB_W-1:0] reg_mem_wb,
  output logic                dmem_req,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [WE_W-1:0]     dmem_we,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic                dmem_ready,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                bus_err,
  output logic                misalign_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  ex_mem_t          w_ex;
  mem_wb_t          w_wb, r_wb;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_addr, r_wdata, r_rdata, w_wdata, w_load;
  logic [WE_W-1:0]  r_we;
  logic             r_err, r_misalign, w_misalign, w_mis_pulse, w_bus_err;
  logic             w_unused_imm;

  assign w_ex         = reg_ex_mem;
  assign w_unused_imm = ^w_ex.imm;

  assign reg_mem_wb   = r_wb;
  assign dmem_req     = (r_state == ST_REQ);
  assign dmem_addr    = r_addr;
  assign dmem_we      = r_we;
  assign dmem_wdata   = r_wdata;
  assign bus_err      = w_bus_err;
  assign misalign_err = r_misalign;

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    case (w_ex.opcode)
      OP_LH, OP_LHU, OP_SH: w_misalign = w_ex.alu_out[0];
      OP_LW, OP_SW:         w_misalign = |w_ex.alu_out[1:0];
      default:              w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Store lane replication
  always_comb begin
    case (w_ex.opcode)
      OP_SB:   w_wdata = {4{w_ex.rv2[7:0]}};
      OP_SH:   w_wdata = {2{w_ex.rv2[15:0]}};
      default: w_wdata = w_ex.rv2;
    endcase
  end

  mem_load_format u_load_format (
    .i_opcode (w_ex.opcode),
    .i_addr   (w_ex.alu_out[1:0]),
    .i_rdata  (r_rdata),
    .o_data_c (w_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state, stall, timeout and the write-back record for this cycle
  always_comb begin
    w_next       = r_state;
    ex_mem_stall = 1'b0;
    w_bus_err    = 1'b0;
    w_mis_pulse  = 1'b0;
    w_wb         = '0;
    case (r_state)
      ST_IDLE: begin
        if (is_mem_op(w_ex.opcode)) begin
          ex_mem_stall = 1'b1;
          w_mis_pulse  = w_misalign;
          w_next       = w_misalign ? ST_RESP : ST_REQ;
        end else begin
          w_wb.pc      = w_ex.pc;
          w_wb.wb_data = w_ex.alu_out;
          w_wb.rs1     = w_ex.rs1;
          w_wb.rs2     = w_ex.rs2;
          w_wb.opcode  = w_ex.opcode;
          w_wb.ctrl_we = w_ex.ctrl_we;
          w_wb.valid   = 1'b1;
        end
      end
      ST_REQ: begin
        ex_mem_stall = 1'b1;
        if (dmem_ready) begin
          w_next = ST_RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_bus_err = 1'b1;
          w_next    = ST_RESP;
        end
      end
      ST_RESP: begin
        w_next      = ST_IDLE;
        w_wb.pc     = w_ex.pc;
        w_wb.rs1    = w_ex.rs1;
        w_wb.rs2    = w_ex.rs2;
        w_wb.opcode = w_ex.opcode;
        w_wb.valid  = 1'b1;
        if (r_err) begin
          w_wb.err = 1'b1;
        end else begin
          w_wb.ctrl_we = w_ex.ctrl_we;
          w_wb.wb_data = is_load(w_ex.opcode) ? w_load : w_ex.alu_out;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Bus drive registers, timeout counter, read-data latch and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb       <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_wb       <= w_wb;
      r_misalign <= w_mis_pulse;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_err <= w_misalign;
          if (w_next == ST_REQ) begin
            r_addr  <= w_ex.alu_out;
            r_we    <= w_ex.we;
            r_wdata <= w_wdata;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_next == ST_RESP) begin
            r_addr  <= '0;
            r_we    <= '0;
            r_wdata <= '0;
            r_err   <= w_bus_err;
            if (dmem_ready) r_rdata <= dmem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (honours MEM_MISALIGN_TRAP_EN if defined).
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [148:0] reg_ex_mem;
  logic         ex_mem_stall;
  logic [82:0]  reg_mem_wb;
  logic         dmem_req;
  logic [31:0]  dmem_addr;
  logic [3:0]   dmem_we;
  logic [31:0]  dmem_wdata;
  logic         dmem_ready;
  logic [31:0]  dmem_rdata;
  logic         bus_err;
  logic         misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-access observations filled in by do_access
  int          stall_n, req_n, berr_n, berr_at, mis_n, unstable_n;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_we;
  logic [82:0] got_wb;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_ex_mem   (reg_ex_mem),
    .ex_mem_stall (ex_mem_stall),
    .reg_mem_wb   (reg_mem_wb),
    .dmem_req     (dmem_req),
    .dmem_addr    (dmem_addr),
    .dmem_we      (dmem_we),
    .dmem_wdata   (dmem_wdata),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .bus_err      (bus_err),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [82:0] got, input logic [82:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [148:0] mk_ex(input logic [31:0] pc, input logic [31:0] alu,
                                         input logic [31:0] rv2, input logic [3:0] we,
                                         input logic [5:0] op, input logic cwe);
    return {cwe, op, 32'h0BAD_F00D, we, 5'd7, 5'd3, rv2, alu, pc};
  endfunction

  function automatic logic [82:0] mk_wb(input logic [31:0] pc, input logic [31:0] wbd,
                                        input logic [5:0] op, input logic cwe,
                                        input logic valid, input logic err);
    return {err, valid, cwe, op, 5'd7, 5'd3, wbd, pc};
  endfunction

  // Apply one record and serve it; ready on REQ cycle rdy_at (0 = never). Bounded at 40 cycles.
  task automatic do_access(input logic [148:0] rec, input int rdy_at, input logic [31:0] rdata);
    bit done = 1'b0;
    stall_n = 0; req_n = 0; berr_n = 0; berr_at = 0; mis_n = 0; unstable_n = 0;
    @(negedge clk);
    reg_ex_mem = rec;
    dmem_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (dmem_req) begin
        req_n++;
        if (req_n == 1) begin
          cap_addr = dmem_addr; cap_we = dmem_we; cap_wdata = dmem_wdata;
        end else if (dmem_addr !== cap_addr || dmem_we !== cap_we || dmem_wdata !== cap_wdata) begin
          unstable_n++;
        end
        dmem_ready = (req_n == rdy_at);
        dmem_rdata = dmem_ready ? rdata : 32'hDEAD_BEEF;
      end else begin
        dmem_ready = 1'b0;
      end
      #1;
      if (misalign_err) mis_n++;
      if (bus_err) begin berr_n++; berr_at = req_n; end
      if (ex_mem_stall) stall_n++;
      else done = 1'b1;
      @(negedge clk);
    end
    check("access_bound", 83'(done), 83'(1));
    got_wb     = reg_mem_wb;
    reg_ex_mem = '0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    reg_ex_mem = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_wb",    83'(reg_mem_wb), 83'(0));
    check("rst_req",   83'(dmem_req),   83'(0));
    check("rst_we",    83'(dmem_we),    83'(0));
    check("rst_stall", 83'(ex_mem_stall), 83'(0));
    rst_n = 1'b1;

    // Pass-through
    do_access(mk_ex(32'h100, 32'h0000_1234, 32'h0, 4'h0, 6'd4, 1'b1), 0, 32'h0);
    check("pass_wb",    got_wb, mk_wb(32'h100, 32'h0000_1234, 6'd4, 1'b1, 1'b1, 1'b0));
    check("pass_stall", 83'(stall_n), 83'(0));
    check("pass_req",   83'(req_n),   83'(0));

    // LB / LBU at lane 3
    do_access(mk_ex(32'h104, 32'h0000_0103, 32'h0, 4'h0, 6'd10, 1'b1), 2, 32'h80FF_0000);
    check("lb_wb",    got_wb, mk_wb(32'h104, 32'hFFFF_FF80, 6'd10, 1'b1, 1'b1, 1'b0));
    check("lb_stall", 83'(stall_n), 83'(3));
    check("lb_req",   83'(req_n),   83'(2));
    check("lb_addr",  83'(cap_addr), 83'(32'h0000_0103));
    check("lb_stable", 83'(unstable_n), 83'(0));
    do_access(mk_ex(32'h108, 32'h0000_0103, 32'h0, 4'h0, 6'd13, 1'b1), 2, 32'h80FF_0000);
    check("lbu_wb", got_wb, mk_wb(32'h108, 32'h0000_0080, 6'd13, 1'b1, 1'b1, 1'b0));

    // Stores
    do_access(mk_ex(32'h10C, 32'h0000_0102, 32'h0000_00AB, 4'b0100, 6'd15, 1'b1), 1, 32'h0);
    check("sb_we",    83'(cap_we),    83'(4'b0100));
    check("sb_wdata", 83'(cap_wdata), 83'(32'hABAB_ABAB));
    check("sb_wb",    got_wb, mk_wb(32'h10C, 32'h0000_0102, 6'd15, 1'b1, 1'b1, 1'b0));
    do_access(mk_ex(32'h110, 32'h0000_0202, 32'h1234_CDEF, 4'b1100, 6'd16, 1'b0), 1, 32'h0);
    check("sh_wdata", 83'(cap_wdata), 83'(32'hCDEF_CDEF));
    check("sh_wb",    got_wb, mk_wb(32'h110, 32'h0000_0202, 6'd16, 1'b0, 1'b1, 1'b0));
    do_access(mk_ex(32'h114, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 6'd17, 1'b0), 3, 32'h0);
    check("sw_wdata", 83'(cap_wdata), 83'(32'hCAFE_F00D));
    check("sw_stall", 83'(stall_n), 83'(4));

    // Halfword loads
    do_access(mk_ex(32'h118, 32'h0000_0402, 32'h0, 4'h0, 6'd11, 1'b1), 1, 32'h8001_7FFF);
    check("lh_wb", got_wb, mk_wb(32'h118, 32'hFFFF_8001, 6'd11, 1'b1, 1'b1, 1'b0));
    do_access(mk_ex(32'h11C, 32'h0000_0400, 32'h0, 4'h0, 6'd14, 1'b1), 1, 32'h8001_F00D);
    check("lhu_wb", got_wb, mk_wb(32'h11C, 32'h0000_F00D, 6'd14, 1'b1, 1'b1, 1'b0));

    // Timeout, and ready arriving in the timeout cycle
    do_access(mk_ex(32'h120, 32'h0000_0500, 32'h0, 4'h0, 6'd12, 1'b1), 0, 32'h0);
    check("to_berr_n",  83'(berr_n),  83'(1));
    check("to_berr_at", 83'(berr_at), 83'(16));
    check("to_stall",   83'(stall_n), 83'(17));
    check("to_wb",      got_wb, mk_wb(32'h120, 32'h0, 6'd12, 1'b0, 1'b1, 1'b1));
    do_access(mk_ex(32'h124, 32'h0000_0504, 32'h0, 4'h0, 6'd12, 1'b1), 16, 32'h1357_9BDF);
    check("rdy16_berr", 83'(berr_n), 83'(0));
    check("rdy16_wb",   got_wb, mk_wb(32'h124, 32'h1357_9BDF, 6'd12, 1'b1, 1'b1, 1'b0));

    // Asynchronous reset mid-access
    @(negedge clk);
    reg_ex_mem = mk_ex(32'h128, 32'h0000_0600, 32'h0, 4'h0, 6'd12, 1'b1);
    dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_req_hi", 83'(dmem_req), 83'(1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_req",  83'(dmem_req),   83'(0));
    check("mid_rst_wb",   83'(reg_mem_wb), 83'(0));
    check("mid_rst_addr", 83'(dmem_addr),  83'(0));
    reg_ex_mem = mk_ex(32'h12C, 32'h0000_0055, 32'h0, 4'h0, 6'd4, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_wb", reg_mem_wb, mk_wb(32'h12C, 32'h0000_0055, 6'd4, 1'b0, 1'b1, 1'b0));

    // Misaligned word access
    do_access(mk_ex(32'h130, 32'h0000_0102, 32'h0, 4'h0, 6'd12, 1'b1), 1, 32'h1122_3344);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_req",   83'(req_n), 83'(0));
    check("mis_pulse", 83'(mis_n), 83'(1));
    check("mis_wb",    got_wb, mk_wb(32'h130, 32'h0, 6'd12, 1'b0, 1'b1, 1'b1));
`else
    check("mis_req",   83'(req_n),    83'(1));
    check("mis_addr",  83'(cap_addr), 83'(32'h0000_0102));
    check("mis_pulse", 83'(mis_n),    83'(0));
    check("mis_wb",    got_wb, mk_wb(32'h130, 32'h1122_3344, 6'd12, 1'b1, 1'b1, 1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
